data_ram_io: RTL

- Responder for the core's data-memory port. It services the core's `ram_ce` / `ram_we` / `ram_sel` / `ram_addr` / `ram_data` requests.
- Two regions:
  - a byte-lane-writable word RAM;
  - a small memory-mapped I/O window holding an interrupt aggregator and a 64-bit cycle counter.
- Closes the interrupt loop: takes the core's `timer_int` plus external lines, and drives the core's 6-bit `int_i` input.
- Sits beside the core at SoC top level, in place of a plain data RAM.

---
 rtl/data_ram_io_pkg.sv | 18 +
 rtl/data_ram_io_irq_agg.sv | 60 ++++++
 rtl/data_ram_io.sv | 93 +++++++++
 3 files changed

// File: rtl/data_ram_io_pkg.sv
// Shared constants for the data-memory responder: region tags, RAM sizing
// and the word offsets of the I/O window registers.
package data_ram_io_pkg;

  localparam int          DefDataMemNum     = 1024;
  localparam int          DefDataMemNumLog2 = 10;
  localparam logic [3:0]  DefIoRegionTag    = 4'h1;
  localparam logic [3:0]  RamRegionTag      = 4'h0;

  localparam int          NumIrq            = 6;

  localparam logic [7:0]  IoPending         = 8'h00;
  localparam logic [7:0]  IoMask            = 8'h04;
  localparam logic [7:0]  IoEdge            = 8'h08;
  localparam logic [7:0]  IoCntLo           = 8'h10;
  localparam logic [7:0]  IoCntHi           = 8'h14;

endpackage

// File: rtl/data_ram_io_irq_agg.sv
// Interrupt aggregator: per-source edge/level capture into PENDING, masking,
// and a registered interrupt vector towards the core.
module data_ram_io_irq_agg
  import data_ram_io_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          offset,
  input  logic [NumIrq-1:0]   wdata,
  input  logic [NumIrq-1:0]   src,
  output logic [31:0]         rdata,
  output logic [NumIrq-1:0]   int_o
);

  logic [NumIrq-1:0] pending;
  logic [NumIrq-1:0] mask;
  logic [NumIrq-1:0] edge_mode;
  logic [NumIrq-1:0] prev;
  logic [NumIrq-1:0] w1c;
  logic [NumIrq-1:0] rise;
  logic [NumIrq-1:0] pending_next;

  // Next PENDING: edge sources latch rises (a rise beats a same-cycle W1C),
  // level sources simply follow the line and ignore W1C.
  always_comb begin
    w1c          = (wr_en && offset == IoPending) ? wdata : '0;
    rise         = src & ~prev;
    pending_next = (edge_mode & ((pending & ~w1c) | rise)) | (~edge_mode & src);
  end

  // Register file, edge history and the registered interrupt vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '0;
      prev      <= '0;
      int_o     <= '0;
    end else begin
      prev    <= src;
      pending <= pending_next;
      int_o   <= pending & mask;
      if (wr_en && offset == IoMask) mask      <= wdata;
      if (wr_en && offset == IoEdge) edge_mode <= wdata;
    end
  end

  // Register read-back; offsets not owned here read as zero.
  always_comb begin
    rdata = '0;
    case (offset)
      IoPending: rdata = {{(32-NumIrq){1'b0}}, pending};
      IoMask:    rdata = {{(32-NumIrq){1'b0}}, mask};
      IoEdge:    rdata = {{(32-NumIrq){1'b0}}, edge_mode};
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_ram_io.sv
// Data-memory responder for the core: byte-lane word RAM in region 0, an I/O
// window with the interrupt aggregator and a 64-bit cycle counter. Every
// access completes in the cycle it is presented, so no stall is ever needed.
module data_ram_io
  import data_ram_io_pkg::*;
#(
  parameter int         DataMemNum     = DefDataMemNum,
  parameter int         DataMemNumLog2 = DefDataMemNumLog2,
  parameter logic [3:0] IoRegionTag    = DefIoRegionTag
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [4:0]  ext_irq_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_o
);

  logic [31:0]               mem [DataMemNum];
  logic [DataMemNumLog2-1:0] word_idx;
  logic [7:0]                io_off;
  logic                      is_ram;
  logic                      is_io;
  logic                      rd_en;
  logic                      wr_en;
  logic [63:0]               cnt;
  logic [31:0]               hi_shadow;
  logic [31:0]               irq_rdata;
  logic                      unused_addr;

  assign word_idx    = addr_i[DataMemNumLog2+1:2];
  assign io_off      = {addr_i[7:2], 2'b00};
  assign is_ram      = addr_i[31:28] == RamRegionTag;
  assign is_io       = addr_i[31:28] == IoRegionTag;
  assign rd_en       = ce_i & ~we_i;
  // Writes presented while reset is asserted are dropped everywhere.
  assign wr_en       = ce_i & we_i & ~rst;
  assign unused_addr = ^{addr_i[27:DataMemNumLog2+2], addr_i[1:0]};

  // RAM write: only the selected byte lanes change; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_i[i]) mem[word_idx][8*i +: 8] <= data_i[8*i +: 8];
      end
    end
  end

  // Free-running counter; a CNT_LO read captures the high word so a following
  // CNT_HI read is coherent with the low word already returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      hi_shadow <= '0;
    end else begin
      cnt <= cnt + 64'd1;
      if (rd_en && is_io && io_off == IoCntLo) hi_shadow <= cnt[63:32];
    end
  end

  data_ram_io_irq_agg u_irq_agg (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en & is_io),
    .offset (io_off),
    .wdata  (data_i[NumIrq-1:0]),
    .src    ({timer_int_i, ext_irq_i}),
    .rdata  (irq_rdata),
    .int_o  (int_o)
  );

  // Combinational read mux; writes, idle cycles and unmapped space read zero.
  always_comb begin
    data_o = '0;
    if (rd_en) begin
      if (is_ram) begin
        data_o = mem[word_idx];
      end else if (is_io) begin
        case (io_off)
          IoCntLo: data_o = cnt[31:0];
          IoCntHi: data_o = hi_shadow;
          default: data_o = irq_rdata;
        endcase
      end
    end
  end

endmodule
